// File: rtl/mem_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Bundles the fetch requester, data requester and shared
//                memory port signals of mem_arbiter into one interface.
//                - i_*   : instruction-fetch requester (req/addr in, ack/rdata out)
//                - d_*   : data requester (req/we/addr/wdata in, ack/rdata out)
//                - mem_* : shared memory port (req/we/addr/wdata out,
//                          rdata/ack in)
//                - timeout : sticky error flag out of the arbiter
//                Modport "slave" is the arbiter's view; "master" is the view
//                of the environment (both requesters plus the memory).
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;
  // fetch requester
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  // data requester
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  // shared memory port
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  // status
  logic        timeout;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr,
           mem_wdata, timeout
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr,
           mem_wdata, timeout
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-requester (fetch / data) arbiter onto one shared memory
//                port. One transaction at a time: IDLE -> BUSY -> RESP.
//                A BUSY wait counter bounds how long the memory may stall;
//                on expiry the requester gets rdata 0 and the sticky timeout
//                flag is raised.
//  Ports       : clk  - clock, rising edge
//                rst  - asynchronous active-high reset
//                bus  - mem_arbiter_if.slave (fetch, data and memory sides)
//  Parameters  : TIMEOUT_CYCLES - max BUSY cycles waiting for mem_ack
//  Config      : MEM_ARBITER_ROUND_ROBIN_EN - when defined, simultaneous
//                requests alternate using a last-granted bit; otherwise the
//                data requester always wins a tie.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_id;        // 1 = data requester owns the transaction
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [7:0]  r_cnt;
  logic        r_timeout;

  logic        w_any_req;
  logic        w_grant_data;
  logic        w_timeout_hit;
  logic        w_mem_req;
  logic        w_mem_we;
  logic        w_i_ack;
  logic        w_d_ack;

  assign w_any_req = bus.i_req | bus.d_req;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  // 1 = fetch was granted last; reset value 0 means "data granted last",
  // so the first tie after reset goes to fetch.
  logic r_last_fetch;

  always_comb begin
    w_grant_data = bus.d_req;
    if (bus.d_req && bus.i_req) begin
      w_grant_data = r_last_fetch;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_fetch <= 1'b0;
    end else if (r_state == IDLE && w_any_req) begin
      r_last_fetch <= ~w_grant_data;
    end
  end
`else
  assign w_grant_data = bus.d_req;
`endif

  // This BUSY cycle is the last one allowed: the counter would reach the
  // limit at the coming edge. Widened so a limit of 255 cannot wrap.
  assign w_timeout_hit = ({1'b0, r_cnt} + 9'd1) >= {1'b0, TIMEOUT_CYCLES};

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and control outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next    = r_state;
    w_mem_req = 1'b0;
    w_mem_we  = 1'b0;
    w_i_ack   = 1'b0;
    w_d_ack   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_next = BUSY;
        end
      end
      BUSY: begin
        w_mem_req = 1'b1;
        w_mem_we  = r_we;
        // A real ack on the final allowed cycle still wins over the timeout.
        if (bus.mem_ack || w_timeout_hit) begin
          w_next = RESP;
        end
      end
      RESP: begin
        w_i_ack = ~r_id;
        w_d_ack = r_id;
        w_next  = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Transaction latches, wait counter, response data, sticky timeout
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id      <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_id  <= w_grant_data;
            r_cnt <= '0;
            if (w_grant_data) begin
              r_we    <= bus.d_we;
              r_addr  <= bus.d_addr;
              r_wdata <= bus.d_wdata;
            end else begin
              r_we    <= 1'b0;
              r_addr  <= bus.i_addr;
              r_wdata <= '0;
            end
          end
        end
        BUSY: begin
          if (bus.mem_ack) begin
            r_rdata <= bus.mem_rdata;
          end else begin
            r_cnt <= r_cnt + 8'd1;
            if (w_timeout_hit) begin
              r_rdata   <= '0;
              r_timeout <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output drive; read data is only presented alongside its ack
  // --------------------------------------------------------------------------
  assign bus.mem_req   = w_mem_req;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.i_ack     = w_i_ack;
  assign bus.d_ack     = w_d_ack;
  assign bus.i_rdata   = w_i_ack ? r_rdata : 32'h0;
  assign bus.d_rdata   = w_d_ack ? r_rdata : 32'h0;
  assign bus.timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter (TIMEOUT_CYCLES = 4).
//                Fixed vector table, hand sequences for tie handling, reset
//                mid-transaction and stray mem_ack, then randomized
//                transactions checked against a transaction-level model.
//                Honors MEM_ARBITER_ROUND_ROBIN_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam logic [7:0] TO = 8'd4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // One transaction: stimulus and expected result.
  typedef struct {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    int          waits;     // wait cycles before mem_ack, -1 = never
    logic [31:0] mem_rd;
    logic        e_data;    // expected winner: 1 = data
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    int          e_busy;    // expected BUSY cycles
    logic        e_timeout;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.i_req     = 1'b0;
    bus.i_addr    = 32'h0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = 32'h0;
    bus.d_wdata   = 32'h0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Drives one transaction from IDLE, plays the memory, checks everything.
  task automatic apply_vec(input vec_t v, input string tag);
    int          busy;
    int          cyc;
    bit          seen;
    bit          stable;
    logic        got_d;
    logic        got_i;
    logic [31:0] rdata;
    logic        f_we;
    logic [31:0] f_addr;
    logic [31:0] f_wdata;
    busy = 0; cyc = 0; seen = 0; stable = 1;
    got_d = 0; got_i = 0; rdata = 32'h0;
    f_we = 0; f_addr = 32'h0; f_wdata = 32'h0;
    bus.i_req   = v.i_req;
    bus.i_addr  = v.i_addr;
    bus.d_req   = v.d_req;
    bus.d_we    = v.d_we;
    bus.d_addr  = v.d_addr;
    bus.d_wdata = v.d_wdata;
    bus.mem_ack = 1'b0;
    while (!seen && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.i_ack || bus.d_ack) begin
        seen  = 1;
        got_d = bus.d_ack;
        got_i = bus.i_ack;
        rdata = bus.d_ack ? bus.d_rdata : bus.i_rdata;
        bus.mem_ack = 1'b0;
      end else if (bus.mem_req) begin
        busy++;
        if (busy == 1) begin
          f_we = bus.mem_we; f_addr = bus.mem_addr; f_wdata = bus.mem_wdata;
        end else if (bus.mem_we !== f_we || bus.mem_addr !== f_addr ||
                     bus.mem_wdata !== f_wdata) begin
          stable = 0;
        end
        // Requester inputs wander while BUSY; the latched transaction must not.
        bus.i_addr  = $urandom;
        bus.d_addr  = $urandom;
        bus.d_wdata = $urandom;
        bus.d_we    = 1'($urandom_range(0, 1));
        if (v.waits >= 0 && busy - 1 == v.waits) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = v.mem_rd;
        end else begin
          bus.mem_ack   = 1'b0;
          bus.mem_rdata = $urandom;
        end
      end else begin
        bus.mem_ack = 1'b0;
      end
    end
    chk({tag, ".ack_seen"},   32'(seen),            32'd1);
    chk({tag, ".grant"},      32'(got_d),           32'(v.e_data));
    chk({tag, ".both_ack"},   32'(got_d & got_i),   32'd0);
    chk({tag, ".mem_we"},     32'(f_we),            32'(v.e_we));
    chk({tag, ".mem_addr"},   f_addr,               v.e_addr);
    chk({tag, ".mem_wdata"},  f_wdata,              v.e_wdata);
    chk({tag, ".stable"},     32'(stable),          32'd1);
    chk({tag, ".rdata"},      rdata,                v.e_rdata);
    chk({tag, ".busy_cyc"},   32'(busy),            32'(v.e_busy));
    chk({tag, ".latency"},    32'(cyc),             32'(v.e_busy + 1));
    chk({tag, ".timeout"},    32'(bus.timeout),     32'(v.e_timeout));
    idle_inputs();
    @(posedge clk);
    #1;
    chk({tag, ".ack_1cyc"}, {29'd0, bus.i_ack, bus.d_ack, bus.mem_req}, 32'd0);
  endtask

  // Plays a zero-wait memory until an ack appears (bounded).
  task automatic wait_ack(output bit got, output logic is_d, output int cyc,
                          input logic [31:0] rd);
    got = 0; is_d = 0; cyc = 0;
    while (!got && cyc < 12) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.i_ack || bus.d_ack) begin
        got  = 1;
        is_d = bus.d_ack;
      end
      bus.mem_ack   = bus.mem_req;
      bus.mem_rdata = rd;
    end
  endtask

  vec_t tbl[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t  v;
    bit    got;
    logic  is_d;
    int    cyc;
    bit    flag;
    logic  m_timeout;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic  m_last_data;
`endif

    // ---------------- reset state ----------------
    idle_inputs();
    rst = 1'b1;
    #2;
    chk("rst.async_outputs", {26'd0, bus.mem_req, bus.mem_we, bus.i_ack, bus.d_ack,
                              bus.timeout, 1'b0}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst.mem_addr",  bus.mem_addr,  32'h0);
    chk("rst.mem_wdata", bus.mem_wdata, 32'h0);

    // ---------------- vector table ----------------
    // order: i_req,i_addr,d_req,d_we,d_addr,d_wdata,waits,mem_rd,
    //        e_data,e_we,e_addr,e_wdata,e_rdata,e_busy,e_timeout
    tbl[0] = '{1'b1, 32'h00400000, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h00000013,
               1'b0, 1'b0, 32'h00400000, 32'h0, 32'h00000013, 1, 1'b0};
    tbl[1] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h10010000, 32'hDEADBEEF, 3, 32'h5555AAAA,
               1'b1, 1'b1, 32'h10010000, 32'hDEADBEEF, 32'h5555AAAA, 4, 1'b0};
    tbl[2] = '{1'b1, 32'h00400004, 1'b0, 1'b0, 32'h0, 32'h0, 2, 32'h00A00093,
               1'b0, 1'b0, 32'h00400004, 32'h0, 32'h00A00093, 3, 1'b0};
    // tie right after a fetch grant: data wins in both configurations
    tbl[3] = '{1'b1, 32'h00400008, 1'b1, 1'b0, 32'h10010010, 32'h12345678, 1, 32'h0BADC0DE,
               1'b1, 1'b0, 32'h10010010, 32'h12345678, 32'h0BADC0DE, 2, 1'b0};
    // memory never answers: 4 BUSY cycles, rdata 0, timeout raised
    tbl[4] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h10010020, 32'hA5A5A5A5, -1, 32'h0,
               1'b1, 1'b1, 32'h10010020, 32'hA5A5A5A5, 32'h0, 4, 1'b1};
    tbl[5] = '{1'b1, 32'h00400010, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h00000073,
               1'b0, 1'b0, 32'h00400010, 32'h0, 32'h00000073, 1, 1'b1};
    // ack on the last allowed BUSY cycle beats the timeout
    tbl[6] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h10010030, 32'h0, 3, 32'h77770001,
               1'b1, 1'b0, 32'h10010030, 32'h0, 32'h77770001, 4, 1'b1};
    tbl[7] = '{1'b1, 32'h0040FFFC, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'h1,
               1'b0, 1'b0, 32'h0040FFFC, 32'h0, 32'h0, 4, 1'b1};
    for (int i = 0; i < 8; i++) begin
      apply_vec(tbl[i], $sformatf("tbl%0d", i));
    end

    // ---------------- reset mid-BUSY ----------------
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h10020000; bus.d_wdata = 32'h13572468;
    flag = 0;
    for (int k = 0; k < 5 && !flag; k++) begin
      @(posedge clk);
      #1;
      if (bus.mem_req) flag = 1;
    end
    chk("rstbusy.reached_busy", 32'(flag), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstbusy.mem_req", 32'(bus.mem_req), 32'd0);
    chk("rstbusy.timeout", 32'(bus.timeout), 32'd0);
    chk("rstbusy.ack", {30'd0, bus.i_ack, bus.d_ack}, 32'd0);
    idle_inputs();
    @(posedge clk);
    #1 rst = 1'b0;
    flag = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus.i_ack || bus.d_ack || bus.mem_req) flag = 1;
    end
    chk("rstbusy.no_ack_after", 32'(flag), 32'd0);

    // ---------------- simultaneous held requests ----------------
    do_reset();
    bus.i_req = 1'b1; bus.i_addr = 32'h00400100;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h10030000;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    m_last_data = 1'b1;   // reset: data counts as granted last
    for (int k = 0; k < 4; k++) begin
      wait_ack(got, is_d, cyc, 32'h0000AB00 + 32'(k));
      chk($sformatf("tie%0d.seen", k), 32'(got), 32'd1);
      chk($sformatf("tie%0d.grant", k), 32'(is_d), 32'(!m_last_data));
      chk($sformatf("tie%0d.cycles", k), 32'(cyc), (k == 0) ? 32'd2 : 32'd3);
      m_last_data = !m_last_data;
    end
`else
    wait_ack(got, is_d, cyc, 32'h0000AB00);
    chk("tie0.seen", 32'(got), 32'd1);
    chk("tie0.grant", 32'(is_d), 32'd1);
    chk("tie0.cycles", 32'(cyc), 32'd2);
    bus.d_req = 1'b0;
    wait_ack(got, is_d, cyc, 32'h0000AB01);
    chk("tie1.seen", 32'(got), 32'd1);
    chk("tie1.grant", 32'(is_d), 32'd0);
    chk("tie1.cycles", 32'(cyc), 32'd3);
`endif
    idle_inputs();
    @(posedge clk);
    #1;

    // ---------------- stray mem_ack in IDLE ----------------
    flag = 0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFFFFFF;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.i_ack || bus.d_ack || bus.mem_req) flag = 1;
    end
    chk("idleack.no_effect", 32'(flag), 32'd0);
    bus.mem_ack = 1'b0;
    v = '{1'b1, 32'h00400200, 1'b0, 1'b0, 32'h0, 32'h0, 1, 32'h11112222,
          1'b0, 1'b0, 32'h00400200, 32'h0, 32'h11112222, 2, 1'b0};
    apply_vec(v, "idleack.next");

    // ---------------- randomized vs reference model ----------------
    do_reset();
    m_timeout = 1'b0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    m_last_data = 1'b1;
`endif
    for (int n = 0; n < 40; n++) begin
      int  sel;
      bit  timed_out;
      sel       = int'($urandom_range(1, 3));
      v.i_req   = (sel != 2);
      v.d_req   = (sel != 1);
      v.i_addr  = $urandom;
      v.d_addr  = $urandom;
      v.d_wdata = $urandom;
      v.d_we    = 1'($urandom_range(0, 1));
      v.waits   = int'($urandom_range(0, 5));
      v.mem_rd  = $urandom;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      v.e_data  = (v.i_req && v.d_req) ? !m_last_data : v.d_req;
      m_last_data = v.e_data;
`else
      v.e_data  = v.d_req;
`endif
      timed_out   = (v.waits >= int'(TO));
      m_timeout   = m_timeout | timed_out;
      v.e_we      = v.e_data ? v.d_we : 1'b0;
      v.e_addr    = v.e_data ? v.d_addr : v.i_addr;
      v.e_wdata   = v.e_data ? v.d_wdata : 32'h0;
      v.e_rdata   = timed_out ? 32'h0 : v.mem_rd;
      v.e_busy    = timed_out ? int'(TO) : v.waits + 1;
      v.e_timeout = m_timeout;
      apply_vec(v, $sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL provide parameter TIMEOUT_CYCLES, default 8'd255, giving the maximum BUSY cycles spent waiting for mem_ack.
REQ-002 The block SHALL provide ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  1  instruction-fetch request, held until i_ack.
- i_addr  in  32  fetch address.
- i_ack  out  1  one-cycle fetch completion pulse.
- i_rdata  out  32  fetched word, valid while i_ack=1.
- d_req  in  1  data request, held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_ack  out  1  one-cycle data completion pulse.
- d_rdata  out  32  load word, valid while d_ack=1.
- mem_req  out  1  shared memory port request.
- mem_we  out  1  shared port write enable.
- mem_addr  out  32  shared port address.
- mem_wdata  out  32  shared port write data.
- mem_rdata  in  32  shared port read data, valid with mem_ack.
- mem_ack  in  1  memory completion, sampled only while mem_req=1.
- timeout  out  1  sticky error flag.

Function
REQ-003 The FSM SHALL have states IDLE, BUSY, RESP and no others.
REQ-004 In IDLE with any request high, the block SHALL latch the winner's id, address, we and wdata (we=0, wdata=0 for fetch) and enter BUSY on the next edge.
REQ-005 In IDLE with i_req and d_req both high, the data requester SHALL win (priority otherwise per REQ-016).
REQ-006 In BUSY, mem_req SHALL be 1 and mem_we/mem_addr/mem_wdata SHALL equal the latched values, stable for the whole BUSY period.
REQ-007 In BUSY with mem_ack=1, the block SHALL register mem_rdata and enter RESP; zero-wait memory (mem_ack in the first BUSY cycle) SHALL be supported.
REQ-008 In RESP, only the granted requester's ack SHALL be 1 for exactly one cycle with its rdata driven, then the FSM SHALL return to IDLE.
REQ-009 Minimum latency SHALL be 2 cycles from a req sampled in IDLE to ack, and minimum throughput one transaction per 3 cycles.
REQ-010 A 8-bit wait counter SHALL clear on BUSY entry and increment each BUSY cycle without mem_ack; on reaching TIMEOUT_CYCLES the block SHALL enter RESP, return rdata 32'h0 and set timeout.
REQ-011 timeout SHALL stay 1 until rst; further transactions SHALL proceed normally.
REQ-012 mem_ack outside BUSY SHALL be ignored, and mem_req, mem_we, i_ack and d_ack SHALL be 0 outside their stated states.
REQ-013 A requester still asserting req in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-014 Request inputs changing during BUSY/RESP SHALL NOT affect the latched transaction.

Reset
REQ-015 On rst=1, asynchronously, the FSM SHALL be IDLE, counter 0, all latches 0, all outputs 0 including timeout, with any in-flight transaction dropped without an ack.

Configuration
REQ-016 With macro MEM_ARBITER_ROUND_ROBIN_EN defined, a last-granted bit (reset 0 = data) SHALL give simultaneous requests to the requester not granted last; undefined, data SHALL always win simultaneous requests and no last-granted register SHALL exist.

Verification
REQ-017 The bench SHALL cover: i_req=1, i_addr=32'h00400000, memory acks in the first BUSY cycle with 32'h00000013 -> mem_addr=32'h00400000, mem_we=0, i_ack=1 with i_rdata=32'h00000013 two cycles after req.
REQ-018 The bench SHALL cover: d_req=1, d_we=1, d_addr=32'h10010000, d_wdata=32'hDEADBEEF, memory acks after 3 wait cycles -> mem_we=1 with the data held stable for 4 cycles, then a single d_ack.
REQ-019 The bench SHALL cover: i_req and d_req high together and held -> data served first; then fetch served, without the macro; and with the macro, alternating grants afterwards.
REQ-020 The bench SHALL cover: mem_ack never asserted with TIMEOUT_CYCLES=4 -> ack with rdata=32'h0 after 4 BUSY cycles, timeout=1 and held through a subsequent good transaction.
REQ-021 The bench SHALL cover: rst pulsed mid-BUSY -> mem_req=0 immediately, no ack, timeout=0, FSM in IDLE.
REQ-022 The bench SHALL cover: mem_ack pulsed while in IDLE -> no ack output and no state change.
